// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer and the shared datapath.
// The master side is the sequencer; the slave side is the datapath and memory.
interface multicycle_control_if;
    logic [5:0] i_opcode;
    logic       i_zero;
    logic       i_mem_ack;
    logic       o_mem_req;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_iord;
    logic       o_ir_write;
    logic       o_pc_write;
    logic [1:0] o_pc_src;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic       o_zero_ext;
    logic [5:0] o_alu_op;
    logic       o_reg_write;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_trap;
    logic [1:0] o_trap_cause;
    logic [3:0] o_state;

    modport master (
        input  i_opcode, i_zero, i_mem_ack,
        output o_mem_req, o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_write,
               o_pc_src, o_alu_src_a, o_alu_src_b, o_zero_ext, o_alu_op,
               o_reg_write, o_reg_dst, o_mem_to_reg, o_trap, o_trap_cause, o_state
    );

    modport slave (
        output i_opcode, i_zero, i_mem_ack,
        input  o_mem_req, o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_write,
               o_pc_src, o_alu_src_a, o_alu_src_b, o_zero_ext, o_alu_op,
               o_reg_write, o_reg_dst, o_mem_to_reg, o_trap, o_trap_cause, o_state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main sequencer of the multi-cycle MIPS core: steps the shared ALU/memory
// datapath through fetch/decode/execute/memory/writeback, with bus timeout and illegal-op traps.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    logic       store_q, store_d;
    logic       mem_req;
    logic       tmo_hit;

    assign mem_req = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // This cycle would be the MEM_TIMEOUT-th unacknowledged one; an ack here still wins.
    assign tmo_hit = mem_req && !bus.i_mem_ack && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        store_d = store_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (bus.i_mem_ack)  state_d = S_DECODE;
                else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                // Load/store direction is latched here so MEMADR need not look at the opcode.
                store_d = (bus.i_opcode == 6'h2B);
                case (bus.i_opcode)
                    6'h23, 6'h2B:               state_d = S_MEMADR;
                    6'h00:                      state_d = S_EXEC;
                    6'h04, 6'h05:               state_d = S_BRANCH;
                    6'h02:                      state_d = S_JUMP;
                    6'h08, 6'h09, 6'h0D, 6'h0F: state_d = S_IEXEC;
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: state_d = store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (bus.i_mem_ack)  state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase

        cnt_d = cnt_q;
        if ((state_d != state_q) || bus.i_mem_ack) cnt_d = 8'd0;
        else if (mem_req)                          cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        bus.o_mem_req    = mem_req;
        bus.o_mem_read   = 1'b0;
        bus.o_mem_write  = 1'b0;
        bus.o_iord       = 1'b0;
        bus.o_ir_write   = 1'b0;
        bus.o_pc_write   = 1'b0;
        bus.o_pc_src     = 2'b00;
        bus.o_alu_src_a  = 1'b0;
        bus.o_alu_src_b  = 2'b00;
        bus.o_zero_ext   = 1'b0;
        bus.o_alu_op     = 6'h00;
        bus.o_reg_write  = 1'b0;
        bus.o_reg_dst    = 1'b0;
        bus.o_mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.o_mem_read  = 1'b1;
                bus.o_alu_src_b = 2'b01;
                bus.o_alu_op    = 6'h08;
                bus.o_ir_write  = bus.i_mem_ack;
                bus.o_pc_write  = bus.i_mem_ack;
            end
            S_DECODE: begin
                bus.o_alu_src_b = 2'b11;
                bus.o_alu_op    = 6'h08;
            end
            S_MEMADR: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_src_b = 2'b10;
                bus.o_alu_op    = 6'h08;
            end
            S_MEMRD: begin
                bus.o_mem_read = 1'b1;
                bus.o_iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.o_reg_write  = 1'b1;
                bus.o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.o_mem_write = 1'b1;
                bus.o_iord      = 1'b1;
            end
            S_EXEC: bus.o_alu_src_a = 1'b1;
            S_ALUWB: begin
                bus.o_reg_write = 1'b1;
                bus.o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_op    = 6'h04;
                bus.o_pc_src    = 2'b01;
                bus.o_pc_write  = ((bus.i_opcode == 6'h04) && bus.i_zero) ||
                                  ((bus.i_opcode == 6'h05) && !bus.i_zero);
            end
            S_JUMP: begin
                bus.o_pc_src   = 2'b10;
                bus.o_pc_write = 1'b1;
            end
            S_IEXEC: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_src_b = 2'b10;
                bus.o_alu_op    = bus.i_opcode;
                bus.o_zero_ext  = (bus.i_opcode == 6'h0D);
            end
            S_IWB: bus.o_reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_trap       = trap_q;
    assign bus.o_trap_cause = cause_q;
    assign bus.o_state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory
// wait states, bus timeout and illegal-opcode trap against hand-computed values.
module tb_multicycle_control;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus.master)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int exp);
        chk(tag, 32'(bus.o_state), 32'(exp));
    endtask

    // Fetch with an immediate ack, landing in DECODE with the given opcode.
    task automatic fetch_fast(input logic [5:0] op);
        bus.i_mem_ack = 1'b1;
        #1;
        chk_st("fetch_st", 1);
        chk("fetch_irw", 32'(bus.o_ir_write), 1);
        tick();
        bus.i_mem_ack = 1'b0;
        bus.i_opcode  = op;
        #1;
        chk_st("decode_st", 2);
    endtask

    initial begin
        bus.i_opcode  = 6'h00;
        bus.i_zero    = 1'b0;
        bus.i_mem_ack = 1'b0;

        // Reset state
        repeat (2) tick();
        chk_st("rst_st", 0);
        chk("rst_trap", 32'(bus.o_trap), 0);
        chk("rst_cause", 32'(bus.o_trap_cause), 0);
        chk("rst_req", 32'(bus.o_mem_req), 0);
        i_rst_n = 1'b1;
        #1;
        chk_st("idle_st", 0);
        tick();
        chk_st("fetch0_st", 1);
        chk("fetch_req", 32'(bus.o_mem_req), 1);
        chk("fetch_rd", 32'(bus.o_mem_read), 1);
        chk("fetch_srcb", 32'(bus.o_alu_src_b), 1);
        chk("fetch_aluop", 32'(bus.o_alu_op), 32'h08);
        chk("fetch_noack_pcw", 32'(bus.o_pc_write), 0);

        // ADDI: 1,2,11,12,1
        fetch_fast(6'h08);
        chk("dec_srcb", 32'(bus.o_alu_src_b), 3);
        chk("dec_regw", 32'(bus.o_reg_write), 0);
        tick();
        chk_st("iexec_st", 11);
        chk("iexec_aluop", 32'(bus.o_alu_op), 32'h08);
        chk("iexec_srcb", 32'(bus.o_alu_src_b), 2);
        chk("iexec_zext", 32'(bus.o_zero_ext), 0);
        chk("iexec_regw", 32'(bus.o_reg_write), 0);
        tick();
        chk_st("iwb_st", 12);
        chk("iwb_regw", 32'(bus.o_reg_write), 1);
        chk("iwb_dst", 32'(bus.o_reg_dst), 0);
        tick();
        chk_st("addi_end", 1);

        // ORI zero-extends
        fetch_fast(6'h0D);
        tick();
        chk("ori_aluop", 32'(bus.o_alu_op), 32'h0D);
        chk("ori_zext", 32'(bus.o_zero_ext), 1);
        tick();
        tick();
        chk_st("ori_end", 1);

        // LW with 3 wait cycles in FETCH and MEMRD
        for (int i = 0; i < 3; i++) begin
            chk_st("lw_fwait_st", 1);
            chk("lw_fwait_irw", 32'(bus.o_ir_write), 0);
            tick();
        end
        fetch_fast(6'h23);
        tick();
        chk_st("memadr_st", 3);
        chk("memadr_srca", 32'(bus.o_alu_src_a), 1);
        chk("memadr_srcb", 32'(bus.o_alu_src_b), 2);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_st("memrd_st", 4);
            chk("memrd_iord", 32'(bus.o_iord), 1);
            tick();
        end
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        #1;
        chk_st("memwb_st", 5);
        chk("memwb_m2r", 32'(bus.o_mem_to_reg), 1);
        chk("memwb_regw", 32'(bus.o_reg_write), 1);
        tick();
        chk_st("lw_end", 1);

        // SW: 4 cycles
        fetch_fast(6'h2B);
        tick();
        tick();
        chk_st("memwr_st", 6);
        chk("memwr_wr", 32'(bus.o_mem_write), 1);
        chk("memwr_rd", 32'(bus.o_mem_read), 0);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        chk_st("sw_end", 1);

        // BEQ taken, BNE not taken with zero=1
        bus.i_zero = 1'b1;
        fetch_fast(6'h04);
        tick();
        chk_st("beq_st", 9);
        chk("beq_pcw", 32'(bus.o_pc_write), 1);
        chk("beq_pcsrc", 32'(bus.o_pc_src), 1);
        chk("beq_aluop", 32'(bus.o_alu_op), 32'h04);
        tick();
        chk_st("beq_end", 1);
        fetch_fast(6'h05);
        tick();
        chk_st("bne_st", 9);
        chk("bne_pcw", 32'(bus.o_pc_write), 0);
        tick();
        chk_st("bne_end", 1);
        bus.i_zero = 1'b0;

        // J
        fetch_fast(6'h02);
        tick();
        chk_st("jump_st", 10);
        chk("jump_pcw", 32'(bus.o_pc_write), 1);
        chk("jump_pcsrc", 32'(bus.o_pc_src), 2);
        tick();
        chk_st("j_end", 1);

        // R-type, reset mid-EXEC
        fetch_fast(6'h00);
        tick();
        chk_st("exec_st", 7);
        chk("exec_srca", 32'(bus.o_alu_src_a), 1);
        chk("exec_aluop", 32'(bus.o_alu_op), 0);
        i_rst_n = 1'b0;
        #1;
        chk_st("async_rst_st", 0);
        tick();
        i_rst_n = 1'b1;
        #1;
        chk_st("post_rst_st", 0);
        chk("post_rst_regw", 32'(bus.o_reg_write), 0);
        chk("post_rst_pcw", 32'(bus.o_pc_write), 0);
        tick();
        chk_st("post_rst_fetch", 1);

        // Ack in the 15th waiting cycle still advances
        repeat (14) tick();
        chk_st("tmo_edge_st", 1);
        chk("tmo_edge_trap", 32'(bus.o_trap), 0);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        chk_st("tmo_ack_decode", 2);

        // Illegal opcode
        bus.i_opcode = 6'h3F;
        #1;
        tick();
        chk_st("ill_st", 13);
        chk("ill_trap", 32'(bus.o_trap), 1);
        chk("ill_cause", 32'(bus.o_trap_cause), 1);
        bus.i_mem_ack = 1'b1;
        bus.i_zero    = 1'b1;
        repeat (3) tick();
        chk_st("ill_hold", 13);
        chk("ill_req", 32'(bus.o_mem_req), 0);
        chk("ill_pcw", 32'(bus.o_pc_write), 0);
        chk("ill_irw", 32'(bus.o_ir_write), 0);
        bus.i_mem_ack = 1'b0;

        // Bus timeout in FETCH
        i_rst_n = 1'b0;
        tick();
        chk("rst2_trap", 32'(bus.o_trap), 0);
        i_rst_n = 1'b1;
        tick();
        repeat (14) tick();
        chk_st("tmo_wait_st", 1);
        tick();
        chk_st("tmo_st", 13);
        chk("tmo_trap", 32'(bus.o_trap), 1);
        chk("tmo_cause", 32'(bus.o_trap_cause), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
